iob_eth_mem_arbiter: RTL and testbench

Two-requester IOb-native arbiter that shares a single system-memory master port between the Ethernet MAC's DMA master (requester 0) and the CPU/loader data port (requester 1). It sits between `iob_ethmac`'s `m_*` interface and the IOb-to-Wishbone bridge that drives the memory. It registers each granted request and grants round-robin. A watchdog aborts any transaction the memory never acknowledges, so a stalled bus cannot hang MAC buffer-descriptor traffic.

---
 rtl/iob_eth_arb_pkg.sv | 12 +
 rtl/iob_eth_arb_rr.sv | 21 ++
 rtl/iob_eth_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_iob_eth_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_arb_pkg.sv
// Shared encodings for the Ethernet DMA / CPU memory arbiter.
package iob_eth_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic REQ_ETH = 1'b0;
    localparam logic REQ_CPU = 1'b1;

endpackage

// File: rtl/iob_eth_arb_rr.sv
// Two-way round-robin pick; the priority pointer is held by the caller.
module iob_eth_arb_rr
    import iob_eth_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic       winner,
    output logic       any_valid
);

    always_comb begin
        any_valid = |valid;
        winner    = REQ_ETH;
        if (&valid) begin
            winner = prio;
        end else if (valid[REQ_CPU]) begin
            winner = REQ_CPU;
        end
    end

endmodule

// File: rtl/iob_eth_mem_arbiter.sv
// Shares one IOb memory master port between the MAC DMA (s0) and the CPU (s1),
// with a watchdog that aborts transactions the memory never acknowledges.
module iob_eth_mem_arbiter
    import iob_eth_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 10
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,

    input  logic                  s0_valid,
    input  logic [ADDR_W-1:0]     s0_address,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wstrb,
    output logic [DATA_W-1:0]     s0_rdata,
    output logic                  s0_ready,
    output logic                  s0_err,

    input  logic                  s1_valid,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wstrb,
    output logic [DATA_W-1:0]     s1_rdata,
    output logic                  s1_ready,
    output logic                  s1_err,

    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_ready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_t           state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 gnt_q, gnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
    logic                 winner, any_valid;
    logic                 done_c, abort_c;

    iob_eth_arb_rr u_rr (
        .valid     ({s1_valid, s0_valid}),
        .prio      (prio_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The watchdog fires on the cycle its count would reach all-ones.
    assign wd_inc = wd_q + TIMEOUT_W'(1);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            prio_q    <= REQ_ETH;
            gnt_q     <= REQ_ETH;
            m_valid_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            m_valid_q <= m_valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        m_valid_d = m_valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wd_d      = wd_q;
        done_c    = 1'b0;
        abort_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d     = winner;
                    addr_d    = (winner == REQ_CPU) ? s1_address : s0_address;
                    wdata_d   = (winner == REQ_CPU) ? s1_wdata   : s0_wdata;
                    wstrb_d   = (winner == REQ_CPU) ? s1_wstrb   : s0_wstrb;
                    m_valid_d = 1'b1;
                    wd_d      = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                wd_d = wd_inc;
                // A real completion takes precedence over a coincident timeout.
                if (m_ready) begin
                    done_c = 1'b1;
                end else if (wd_inc == {TIMEOUT_W{1'b1}}) begin
                    abort_c = 1'b1;
                end
                if (done_c || abort_c) begin
                    m_valid_d = 1'b0;
                    prio_d    = ~gnt_q;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    assign m_valid   = m_valid_q;
    assign m_address = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;

    // Response demux: only the granted requester ever sees ready/err/rdata.
    always_comb begin
        s0_ready = 1'b0;
        s0_err   = 1'b0;
        s0_rdata = '0;
        s1_ready = 1'b0;
        s1_err   = 1'b0;
        s1_rdata = '0;
        if (gnt_q == REQ_ETH) begin
            s0_ready = done_c | abort_c;
            s0_err   = abort_c;
            s0_rdata = done_c ? m_rdata : '0;
        end else begin
            s1_ready = done_c | abort_c;
            s1_err   = abort_c;
            s1_rdata = done_c ? m_rdata : '0;
        end
    end

endmodule

// File: tb/tb_iob_eth_mem_arbiter.sv
// Bench for iob_eth_mem_arbiter: directed table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_iob_eth_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TW  = 4;
    localparam int unsigned TMO = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          s0_valid, s1_valid;
    logic [AW-1:0] s0_address, s1_address;
    logic [DW-1:0] s0_wdata, s1_wdata;
    logic [SW-1:0] s0_wstrb, s1_wstrb;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic          s0_ready, s1_ready, s0_err, s1_err;
    logic          m_valid;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_eth_mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .s0_valid   (s0_valid),
        .s0_address (s0_address),
        .s0_wdata   (s0_wdata),
        .s0_wstrb   (s0_wstrb),
        .s0_rdata   (s0_rdata),
        .s0_ready   (s0_ready),
        .s0_err     (s0_err),
        .s1_valid   (s1_valid),
        .s1_address (s1_address),
        .s1_wdata   (s1_wdata),
        .s1_wstrb   (s1_wstrb),
        .s1_rdata   (s1_rdata),
        .s1_ready   (s1_ready),
        .s1_err     (s1_err),
        .m_valid    (m_valid),
        .m_address  (m_address),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready)
    );

    typedef struct packed {
        logic          s0v, s1v;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [SW-1:0] w0, w1;
        logic          mr;
        logic [DW-1:0] mrd;
        logic          e_mv;
        logic [AW-1:0] e_ma;
        logic [DW-1:0] e_md;
        logic [SW-1:0] e_mw;
        logic          e_r0, e_r1, e_e0, e_e1;
        logic [DW-1:0] e_rd0, e_rd1;
    } vec_t;

    vec_t tbl[$];

    // Transaction-level reference model and random requester agents.
    logic          md_busy;
    logic          md_who, md_next;
    int            md_age;
    logic [AW-1:0] md_a;
    logic [DW-1:0] md_d;
    logic [SW-1:0] md_w;
    logic          e_rdy[2], e_er[2];
    logic [DW-1:0] e_rd[2];
    logic          rq_v[2];
    logic [AW-1:0] rq_a[2];
    logic [DW-1:0] rq_d[2];
    logic [SW-1:0] rq_w[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        s0_valid = 0; s1_valid = 0;
        s0_address = '0; s1_address = '0;
        s0_wdata = '0; s1_wdata = '0;
        s0_wstrb = '0; s1_wstrb = '0;
        m_ready = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        arst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        arst_n = 1;
    endtask

    task automatic apply_row(input vec_t v, input int i);
        tick();
        s0_valid = v.s0v; s1_valid = v.s1v;
        s0_address = v.a0; s1_address = v.a1;
        s0_wdata = v.d0; s1_wdata = v.d1;
        s0_wstrb = v.w0; s1_wstrb = v.w1;
        m_ready = v.mr; m_rdata = v.mrd;
        settle();
        chk($sformatf("tbl%0d.m_valid", i), m_valid, v.e_mv);
        chk($sformatf("tbl%0d.m_address", i), m_address, v.e_ma);
        chk($sformatf("tbl%0d.m_wdata", i), m_wdata, v.e_md);
        chk($sformatf("tbl%0d.m_wstrb", i), m_wstrb, v.e_mw);
        chk($sformatf("tbl%0d.s0_ready", i), s0_ready, v.e_r0);
        chk($sformatf("tbl%0d.s1_ready", i), s1_ready, v.e_r1);
        chk($sformatf("tbl%0d.s0_err", i), s0_err, v.e_e0);
        chk($sformatf("tbl%0d.s1_err", i), s1_err, v.e_e1);
        chk($sformatf("tbl%0d.s0_rdata", i), s0_rdata, v.e_rd0);
        chk($sformatf("tbl%0d.s1_rdata", i), s1_rdata, v.e_rd1);
    endtask

    task automatic build_table();
        vec_t          v;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic [SW-1:0] lw;
        la = '0; ld = '0; lw = '0;
        // Both requesters hold valid, zero-wait memory: grants alternate 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++) begin
            v = '0;
            v.s0v = 1; v.s1v = 1;
            v.a0 = 32'h10; v.a1 = 32'h20;
            v.d0 = 32'h1111_1111; v.d1 = 32'h2222_2222;
            v.w0 = 4'hF; v.w1 = 4'hF;
            v.mr = 1; v.mrd = 32'h5A5A_5A5A;
            v.e_ma = la; v.e_md = ld; v.e_mw = lw;
            tbl.push_back(v);
            la = (k % 2 == 1) ? 32'h20 : 32'h10;
            ld = (k % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111;
            lw = 4'hF;
            v.e_mv = 1; v.e_ma = la; v.e_md = ld; v.e_mw = lw;
            if (k % 2 == 1) begin
                v.e_r1 = 1; v.e_rd1 = 32'h5A5A_5A5A;
            end else begin
                v.e_r0 = 1; v.e_rd0 = 32'h5A5A_5A5A;
            end
            tbl.push_back(v);
        end
        // Single read from s0, memory answers on the 4th cycle of m_valid.
        v = '0;
        v.s0v = 1; v.a0 = 32'h100; v.a1 = 32'h20; v.mrd = 32'h7777_7777;
        v.e_ma = la; v.e_md = ld; v.e_mw = lw;
        tbl.push_back(v);
        v.e_mv = 1; v.e_ma = 32'h100; v.e_md = '0; v.e_mw = '0;
        repeat (3) tbl.push_back(v);
        v.mr = 1; v.mrd = 32'hCAFE_F00D; v.e_r0 = 1; v.e_rd0 = 32'hCAFE_F00D;
        tbl.push_back(v);
        v.s0v = 0; v.mr = 0; v.e_mv = 0; v.e_r0 = 0; v.e_rd0 = '0;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        md_busy = 0; md_who = 0; md_next = 0; md_age = 0;
        md_a = '0; md_d = '0; md_w = '0;
        for (int i = 0; i < 2; i++) begin
            rq_v[i] = 0; rq_a[i] = '0; rq_d[i] = '0; rq_w[i] = '0;
        end
    endtask

    task automatic model_expect();
        for (int i = 0; i < 2; i++) begin
            e_rdy[i] = 0; e_er[i] = 0; e_rd[i] = '0;
        end
        if (md_busy) begin
            if (m_ready) begin
                e_rdy[md_who] = 1;
                e_rd[md_who]  = m_rdata;
            end else if (md_age == int'(TMO)) begin
                e_rdy[md_who] = 1;
                e_er[md_who]  = 1;
            end
        end
    endtask

    task automatic model_advance();
        int w;
        if (md_busy) begin
            if (e_rdy[md_who]) begin
                md_busy = 0;
                md_next = ~md_who;
            end else begin
                md_age++;
            end
        end else if (rq_v[0] || rq_v[1]) begin
            if (rq_v[0] && rq_v[1]) w = int'(md_next);
            else w = rq_v[1] ? 1 : 0;
            md_who = w[0];
            md_a = rq_a[w]; md_d = rq_d[w]; md_w = rq_w[w];
            md_busy = 1;
            md_age = 1;
        end
    endtask

    task automatic run_random(input int cycles);
        int pct;
        for (int c = 0; c < cycles; c++) begin
            pct = (c < cycles / 2) ? 50 : 4;
            tick();
            s0_valid = rq_v[0]; s0_address = rq_a[0]; s0_wdata = rq_d[0]; s0_wstrb = rq_w[0];
            s1_valid = rq_v[1]; s1_address = rq_a[1]; s1_wdata = rq_d[1]; s1_wstrb = rq_w[1];
            m_ready = ($urandom_range(0, 99) < pct);
            m_rdata = $urandom;
            settle();
            model_expect();
            chk($sformatf("rnd%0d.m_valid", c), m_valid, md_busy);
            chk($sformatf("rnd%0d.m_address", c), m_address, md_a);
            chk($sformatf("rnd%0d.m_wdata", c), m_wdata, md_d);
            chk($sformatf("rnd%0d.m_wstrb", c), m_wstrb, md_w);
            chk($sformatf("rnd%0d.s0_ready", c), s0_ready, e_rdy[0]);
            chk($sformatf("rnd%0d.s1_ready", c), s1_ready, e_rdy[1]);
            chk($sformatf("rnd%0d.s0_err", c), s0_err, e_er[0]);
            chk($sformatf("rnd%0d.s1_err", c), s1_err, e_er[1]);
            chk($sformatf("rnd%0d.s0_rdata", c), s0_rdata, e_rd[0]);
            chk($sformatf("rnd%0d.s1_rdata", c), s1_rdata, e_rd[1]);
            model_advance();
            for (int i = 0; i < 2; i++) begin
                if (e_rdy[i] || !rq_v[i]) begin
                    rq_v[i] = e_rdy[i] ? $urandom_range(0, 1) == 1 : $urandom_range(0, 2) == 0;
                    rq_a[i] = $urandom;
                    rq_d[i] = $urandom;
                    rq_w[i] = SW'($urandom);
                end
            end
        end
    endtask

    initial begin
        int   cnt;
        logic seen;

        arst_n = 0;
        clear_inputs();
        m_ready = 1;
        m_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst.m_valid", m_valid, 0);
        chk("rst.m_address", m_address, 0);
        chk("rst.m_wdata", m_wdata, 0);
        chk("rst.m_wstrb", m_wstrb, 0);
        chk("rst.s0_ready", s0_ready, 0);
        chk("rst.s1_ready", s1_ready, 0);
        chk("rst.s0_err", s0_err, 0);
        chk("rst.s0_rdata", s0_rdata, 0);
        chk("rst.s1_rdata", s1_rdata, 0);
        do_reset();

        build_table();
        foreach (tbl[i]) apply_row(tbl[i], i);

        // Payload stays frozen while s1 changes its address mid-transaction.
        tick(); s1_valid = 1; s1_address = 32'h40; s1_wdata = 32'hA5; s1_wstrb = 4'h3; m_ready = 0; settle();
        tick(); settle();
        chk("frz.m_valid", m_valid, 1);
        chk("frz.m_address0", m_address, 32'h40);
        tick(); s1_address = 32'h80; settle();
        chk("frz.m_address1", m_address, 32'h40);
        tick(); settle();
        chk("frz.m_address2", m_address, 32'h40);
        tick(); m_ready = 1; m_rdata = 32'h1234_5678; settle();
        chk("frz.s1_ready", s1_ready, 1);
        chk("frz.s1_rdata", s1_rdata, 32'h1234_5678);
        chk("frz.s0_ready", s0_ready, 0);
        chk("frz.m_address3", m_address, 32'h40);
        tick(); s1_valid = 0; m_ready = 0; settle();
        chk("frz.m_valid_low", m_valid, 0);

        // Watchdog abort on the TMO-th cycle of m_valid, then a normal grant.
        tick(); s0_valid = 1; s0_address = 32'h200; s0_wstrb = '0; m_ready = 0; m_rdata = 32'hFFFF_FFFF; settle();
        cnt = 0; seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick(); settle();
            if (m_valid) cnt++;
            if (s0_ready || s1_ready) seen = 1;
        end
        chk("wd.seen", seen, 1);
        chk("wd.cycles", cnt, TMO);
        chk("wd.s0_err", s0_err, 1);
        chk("wd.s0_rdata", s0_rdata, 0);
        chk("wd.s1_ready", s1_ready, 0);
        tick(); s0_valid = 0; s1_valid = 1; s1_address = 32'h300; settle();
        chk("wd.m_valid_low", m_valid, 0);
        chk("wd.s0_ready_low", s0_ready, 0);
        tick(); settle();
        chk("wd.next_m_valid", m_valid, 1);
        chk("wd.next_m_address", m_address, 32'h300);
        tick(); m_ready = 1; m_rdata = 32'hABCD_0123; settle();
        chk("wd.next_s1_ready", s1_ready, 1);
        chk("wd.next_s1_err", s1_err, 0);
        chk("wd.next_s1_rdata", s1_rdata, 32'hABCD_0123);
        tick(); s1_valid = 0; m_ready = 0; settle();

        // m_ready coincident with the terminal watchdog cycle completes normally.
        tick(); s0_valid = 1; s0_address = 32'h400; settle();
        for (int n = 1; n <= int'(TMO); n++) begin
            tick();
            if (n == int'(TMO)) begin
                m_ready = 1; m_rdata = 32'h0BAD_BEEF;
            end
            settle();
        end
        chk("coin.s0_ready", s0_ready, 1);
        chk("coin.s0_err", s0_err, 0);
        chk("coin.s0_rdata", s0_rdata, 32'h0BAD_BEEF);
        tick(); s0_valid = 0; m_ready = 0; settle();

        // Reset while BUSY: immediate return to reset values, prio back to s0.
        tick(); s0_valid = 1; s0_address = 32'h500; settle();
        tick(); settle();
        chk("rstb.busy", m_valid, 1);
        #2;
        m_ready = 1; m_rdata = 32'h99; arst_n = 0;
        #1;
        chk("rstb.m_valid", m_valid, 0);
        chk("rstb.m_address", m_address, 0);
        chk("rstb.s0_ready", s0_ready, 0);
        chk("rstb.s1_ready", s1_ready, 0);
        tick(); settle();
        chk("rstb.hold_s0_ready", s0_ready, 0);
        arst_n = 1; m_ready = 0; s0_valid = 0;
        tick(); s0_valid = 1; s1_valid = 1; s1_address = 32'h600; settle();
        chk("rstb.idle", m_valid, 0);
        tick(); settle();
        chk("rstb.grant_valid", m_valid, 1);
        chk("rstb.grant_s0", m_address, 32'h500);
        tick(); m_ready = 1; m_rdata = 32'h55; settle();
        chk("rstb.s0_done", s0_ready, 1);
        tick(); s0_valid = 0; m_ready = 0; settle();
        tick(); settle();
        chk("rstb.s1_grant", m_address, 32'h600);
        tick(); m_ready = 1; m_rdata = 32'h66; settle();
        chk("rstb.s1_done", s1_ready, 1);
        chk("rstb.s1_rdata", s1_rdata, 32'h66);
        tick(); s1_valid = 0; m_ready = 0; settle();

        do_reset();
        model_reset();
        run_random(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
